// File: rtl/pll_lock_sequencer.sv
// PLL power-up and lock sequencer: sequences PLL power-down and reset, qualifies LOCK over a
// stability window and releases the system reset request only while lock is stable.
module pll_lock_sequencer #(
    parameter int unsigned ARST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_powerdown_n,
    output logic       pll_arst_n,
    output logic       sys_rstn,
    output logic       locked,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    localparam logic [2:0] StOff      = 3'd0;
    localparam logic [2:0] StArst     = 3'd1;
    localparam logic [2:0] StWaitLock = 3'd2;
    localparam logic [2:0] StStable   = 3'd3;
    localparam logic [2:0] StRun      = 3'd4;
    localparam logic [2:0] StFail     = 3'd5;

    localparam logic [CNT_W-1:0] ArstLast    = CNT_W'(ARST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RetryMax    = 2'(MAX_RETRY);

    logic             lock_meta_q;
    logic             lock_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             cnt_clr;
    logic             retry_take;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        cnt_clr    = 1'b0;
        retry_take = 1'b0;
        if (!enable) begin
            state_d = StOff;
        end else if (restart) begin
            state_d = StArst;
            retry_d = 2'd0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                StOff:      state_d = StArst;
                StArst:     if (cnt_q == ArstLast) state_d = StWaitLock;
                StWaitLock: begin
                    if (lock_s_q) state_d = StStable;
                    else if (cnt_q == TimeoutLast) retry_take = 1'b1;
                end
                StStable: begin
                    // A lock dropout here is a glitch: re-arm the timeout without counting a retry.
                    if (!lock_s_q) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = 2'd0;
                    end
                end
                StRun:      if (!lock_s_q) retry_take = 1'b1;
                StFail:     state_d = StFail;
                default:    state_d = StOff;
            endcase
            if (retry_take) begin
                if (retry_q == RetryMax) begin
                    state_d = StFail;
                end else begin
                    state_d = StArst;
                    retry_d = retry_q + 2'd1;
                end
            end
        end
        // OFF and FAIL have no timed exit, so the counter idles at zero there.
        if (cnt_clr || (state_d != state_q) || (state_q == StOff) || (state_q == StFail)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_meta_q     <= 1'b0;
            lock_s_q        <= 1'b0;
            state_q         <= StOff;
            cnt_q           <= '0;
            retry_q         <= 2'd0;
            pll_powerdown_n <= 1'b0;
            pll_arst_n      <= 1'b0;
            sys_rstn        <= 1'b0;
            locked          <= 1'b0;
            fail            <= 1'b0;
        end else begin
            lock_meta_q     <= pll_lock;
            lock_s_q        <= lock_meta_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            pll_powerdown_n <= (state_d == StArst) || (state_d == StWaitLock) ||
                               (state_d == StStable) || (state_d == StRun);
            pll_arst_n      <= (state_d == StWaitLock) || (state_d == StStable) ||
                               (state_d == StRun);
            sys_rstn        <= (state_d == StRun);
            locked          <= (state_d == StRun);
            fail            <= (state_d == StFail);
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios plus a random lock
// phase, every cycle compared against a countdown-based behavioural model.
module tb_pll_lock_sequencer;

    localparam int ArstCycles   = 16;
    localparam int LockTimeout  = 4096;
    localparam int StableCycles = 256;
    localparam int MaxRetry     = 3;

    logic       clk = 1'b0;
    logic       rstn, enable, restart, pll_lock;
    logic       pll_powerdown_n, pll_arst_n, sys_rstn, locked, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, cycles left in the timed phase, retries, lock delay line.
    int m_state = 0;
    int m_left  = 0;
    int m_retry = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    pll_lock_sequencer dut (
        .clk             (clk),
        .rstn            (rstn),
        .enable          (enable),
        .restart         (restart),
        .pll_lock        (pll_lock),
        .pll_powerdown_n (pll_powerdown_n),
        .pll_arst_n      (pll_arst_n),
        .sys_rstn        (sys_rstn),
        .locked          (locked),
        .fail            (fail),
        .retry_cnt       (retry_cnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] model_vec();
        logic pd, ar, sy;
        pd = (m_state >= 1) && (m_state <= 4);
        ar = (m_state >= 2) && (m_state <= 4);
        sy = (m_state == 4);
        return {3'(m_state), 2'(m_retry), pd, ar, sy, sy, 1'(m_state == 5)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {state, retry_cnt, pll_powerdown_n, pll_arst_n, sys_rstn, locked, fail};
    endfunction

    function automatic void model_retry();
        if (m_retry == MaxRetry) begin
            m_state = 5;
        end else begin
            m_retry++;
            m_state = 1;
            m_left  = ArstCycles;
        end
    endfunction

    function automatic void model_step();
        bit ls;
        if (!rstn) begin
            m_state = 0; m_left = 0; m_retry = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        ls = m_s2;
        if (!enable) begin
            m_state = 0;
        end else if (restart) begin
            m_state = 1; m_left = ArstCycles; m_retry = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_left = ArstCycles; end
                1: if (m_left == 1) begin m_state = 2; m_left = LockTimeout; end
                   else m_left--;
                2: if (ls) begin m_state = 3; m_left = StableCycles; end
                   else if (m_left == 1) model_retry();
                   else m_left--;
                3: if (!ls) begin m_state = 2; m_left = LockTimeout; end
                   else if (m_left == 1) begin m_state = 4; m_retry = 0; end
                   else m_left--;
                4: if (!ls) model_retry();
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = pll_lock;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle_model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    // which: 0 state==st, 1 pll_arst_n high, 2 sys_rstn high, 3 fail high
    task automatic tick_until(input int which, input int st, input int bound, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < bound) begin
            tick();
            n++;
            case (which)
                0:       hit = (state === 3'(st));
                1:       hit = (pll_arst_n === 1'b1);
                2:       hit = (sys_rstn === 1'b1);
                default: hit = (fail === 1'b1);
            endcase
        end
        check("wait_bound", 32'(hit), 32'd1);
    endtask

    initial begin
        int n;
        int low;
        int hold;
        bit done;

        rstn = 1'b0; enable = 1'b0; restart = 1'b0; pll_lock = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(dut_vec()), 32'd0);
        rstn = 1'b1;

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_ignored_off", 32'(state), 32'd0);

        // Bring-up: ARST width, then lock 100 cycles after ARST release.
        enable = 1'b1;
        low    = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (pll_powerdown_n === 1'b1 && pll_arst_n === 1'b0) low++;
            if (pll_arst_n === 1'b1) done = 1'b1;
        end
        check("arst_low_cycles", 32'(low), 32'd16);
        repeat (100) tick();
        pll_lock = 1'b1;
        tick_until(2, 0, 400, n);
        check("lock_to_sysrstn", 32'(n), 32'd259);
        check("locked_in_run", 32'(locked), 32'd1);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        tick();
        tick();
        check("run_held_two_edges", 32'(sys_rstn), 32'd1);
        tick();
        check("loss_sys_rstn", 32'(sys_rstn), 32'd0);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_state", 32'(state), 32'd1);
        check("loss_retry", 32'(retry_cnt), 32'd1);
        check("loss_arst_n", 32'(pll_arst_n), 32'd0);

        // Glitch in STABLE at cnt=100 keeps the retry count.
        tick_until(1, 0, 40, n);
        pll_lock = 1'b1;
        tick_until(0, 3, 10, n);
        repeat (100) tick();
        pll_lock = 1'b0;
        repeat (10) tick();
        check("glitch_state", 32'(state), 32'd2);
        check("glitch_retry", 32'(retry_cnt), 32'd1);
        check("glitch_sys_rstn", 32'(sys_rstn), 32'd0);
        pll_lock = 1'b1;
        tick_until(2, 0, 400, n);
        check("relock_to_run", 32'(n), 32'd259);
        check("run_retry_cleared", 32'(retry_cnt), 32'd0);

        // enable low in RUN.
        enable = 1'b0;
        tick();
        check("disable_state", 32'(state), 32'd0);
        check("disable_powerdown_n", 32'(pll_powerdown_n), 32'd0);
        check("disable_sys_rstn", 32'(sys_rstn), 32'd0);

        // rstn pulse during WAIT_LOCK.
        pll_lock = 1'b0;
        enable   = 1'b1;
        tick_until(0, 2, 40, n);
        repeat (50) tick();
        rstn = 1'b0;
        tick();
        check("rstn_mid_wait", 32'(dut_vec()), 32'd0);
        rstn = 1'b1;

        // No lock at all: four attempts then FAIL.
        tick_until(3, 0, 17000, n);
        check("cycles_to_fail", 32'(n), 32'd16449);
        check("fail_state", 32'(state), 32'd5);
        check("fail_powerdown_n", 32'(pll_powerdown_n), 32'd0);
        check("fail_retry", 32'(retry_cnt), 32'd3);
        repeat (20) tick();
        check("fail_held", 32'(state), 32'd5);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_state", 32'(state), 32'd1);
        check("restart_retry", 32'(retry_cnt), 32'd0);
        check("restart_fail", 32'(fail), 32'd0);
        check("restart_powerdown_n", 32'(pll_powerdown_n), 32'd1);

        // Random lock behaviour with occasional restart and disable.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                pll_lock = ($urandom_range(0, 3) != 0);
                hold     = $urandom_range(1, 400);
            end
            hold--;
            restart = ($urandom_range(0, 499) == 0);
            enable  = ($urandom_range(0, 799) != 0);
            tick();
        end
        restart = 1'b0;
        enable  = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
